// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the datapath control sequencer: opcodes, ALU codes,
// one-hot state encodings and the decoded-instruction struct.
package cpu_ctrl_pkg;

  localparam int OPCODE_W = 5;
  localparam int ALU_OP_W = 4;

  localparam logic [OPCODE_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_ST   = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPCODE_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPCODE_W-1:0] OP_SHL  = 5'b01000;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPCODE_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPCODE_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11011;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SHR = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SHL = 4'd5;

  typedef enum logic [9:0] {
    S_IDLE = 10'b00_0000_0001,
    S_T0   = 10'b00_0000_0010,
    S_T1   = 10'b00_0000_0100,
    S_T2   = 10'b00_0000_1000,
    S_T3   = 10'b00_0001_0000,
    S_T4   = 10'b00_0010_0000,
    S_T5   = 10'b00_0100_0000,
    S_T6   = 10'b00_1000_0000,
    S_T7   = 10'b01_0000_0000,
    S_HALT = 10'b10_0000_0000
  } state_t;

  typedef struct packed {
    logic                is_rtype;
    logic                is_imm;
    logic                is_ld;
    logic                is_st;
    logic                is_nop;
    logic                is_halt;
    logic                illegal;
    logic [ALU_OP_W-1:0] alu_op;
  } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode classifier: instruction class flags plus the ALU function to use.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output dec_t                dec
);

  // Pure table lookup; anything not listed is flagged illegal.
  always_comb begin
    dec        = '0;
    dec.alu_op = ALU_ADD;
    case (opcode)
      OP_LD:   dec.is_ld = 1'b1;
      OP_ST:   dec.is_st = 1'b1;
      OP_ADD:  dec.is_rtype = 1'b1;
      OP_SUB:  begin dec.is_rtype = 1'b1; dec.alu_op = ALU_SUB; end
      OP_AND:  begin dec.is_rtype = 1'b1; dec.alu_op = ALU_AND; end
      OP_OR:   begin dec.is_rtype = 1'b1; dec.alu_op = ALU_OR;  end
      OP_SHR:  begin dec.is_rtype = 1'b1; dec.alu_op = ALU_SHR; end
      OP_SHL:  begin dec.is_rtype = 1'b1; dec.alu_op = ALU_SHL; end
      OP_ADDI: dec.is_imm = 1'b1;
      OP_ANDI: begin dec.is_imm = 1'b1; dec.alu_op = ALU_AND; end
      OP_ORI:  begin dec.is_imm = 1'b1; dec.alu_op = ALU_OR;  end
      OP_NOP:  dec.is_nop = 1'b1;
      OP_HALT: dec.is_halt = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Datapath control FSM: fetch (T0-T2) and execute (T3-T7) sequencing with
// Moore-decoded bus-source, load-enable, ALU and memory-strobe outputs.
// Every state drives at most one bus source.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW    = OPCODE_W,
  parameter int ALUOPW = ALU_OP_W
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              run,
  input  logic [OPW-1:0]    ir_opcode,
  input  logic              mem_done,
  output logic              pc_out,
  output logic              zlow_out,
  output logic              mdr_out,
  output logic              r_out,
  output logic              ba_out,
  output logic              c_out,
  output logic              gra,
  output logic              grb,
  output logic              grc,
  output logic              pc_in,
  output logic              mar_in,
  output logic              mdr_in,
  output logic              ir_in,
  output logic              y_in,
  output logic              z_in,
  output logic              r_in,
  output logic              inc_pc,
  output logic              read,
  output logic              write,
  output logic [ALUOPW-1:0] alu_op,
  output logic              halted,
  output logic              illegal_op
);

  state_t state, nxt;
  dec_t   dec;
  logic   alu_like, mem_op;

  ctrl_decode u_dec (.opcode(ir_opcode), .dec(dec));

  assign alu_like = dec.is_rtype | dec.is_imm;
  assign mem_op   = dec.is_ld | dec.is_st;

  // State register; clear_n drops straight to IDLE, so outputs clear at once.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state <= S_IDLE;
    else          state <= nxt;
  end

  // Next-state: memory waits hold in T1 (fetch), T6 (LD) and T7 (ST).
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (run) nxt = S_T0;
      S_T0:   nxt = S_T1;
      S_T1:   if (mem_done) nxt = S_T2;
      S_T2:   nxt = dec.is_nop ? S_T0 : (dec.is_halt ? S_HALT : S_T3);
      S_T3:   nxt = (alu_like | mem_op) ? S_T4 : S_T0;
      S_T4:   nxt = S_T5;
      S_T5:   nxt = mem_op ? S_T6 : S_T0;
      S_T6:   if (dec.is_st | mem_done) nxt = S_T7;
      S_T7:   if (dec.is_ld | mem_done) nxt = S_T0;
      S_HALT: nxt = S_HALT;
      default: nxt = S_IDLE;
    endcase
  end

  // Output decode from state and opcode only, so waits hold outputs steady.
  always_comb begin
    {pc_out, zlow_out, mdr_out, r_out, ba_out, c_out} = '0;
    {gra, grb, grc}                                   = '0;
    {pc_in, mar_in, mdr_in, ir_in, y_in, z_in, r_in}  = '0;
    {inc_pc, read, write, halted, illegal_op}         = '0;
    alu_op = ALU_ADD;
    unique case (state)
      S_T0: begin pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1; end
      S_T1: begin zlow_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1; end
      S_T2: begin mdr_out = 1'b1; ir_in = 1'b1; end
      S_T3: begin
        if (alu_like)    begin grb = 1'b1; r_out  = 1'b1; y_in = 1'b1; end
        else if (mem_op) begin grb = 1'b1; ba_out = 1'b1; y_in = 1'b1; end
        else             illegal_op = dec.illegal;
      end
      S_T4: begin
        z_in   = 1'b1;
        alu_op = dec.alu_op;
        if (dec.is_rtype) begin grc = 1'b1; r_out = 1'b1; end
        else              c_out = 1'b1;
      end
      S_T5: begin
        zlow_out = 1'b1;
        if (mem_op) mar_in = 1'b1;
        else        begin gra = 1'b1; r_in = 1'b1; end
      end
      S_T6: begin
        if (dec.is_ld)      begin read = 1'b1; mdr_in = 1'b1; end
        else if (dec.is_st) begin gra = 1'b1; r_out = 1'b1; mdr_in = 1'b1; end
      end
      S_T7: begin
        if (dec.is_ld)      begin mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
        else if (dec.is_st) write = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: per-instruction expected micro-step lists built from
// the instruction-class rules, compared cycle by cycle under random mem_done.
module tb_control_sequencer;

  logic       clock = 1'b0;
  logic       clear_n, run, mem_done;
  logic [4:0] ir_opcode;
  logic pc_out, zlow_out, mdr_out, r_out, ba_out, c_out, gra, grb, grc;
  logic pc_in, mar_in, mdr_in, ir_in, y_in, z_in, r_in, inc_pc, read, write;
  logic halted, illegal_op;
  logic [3:0] alu_op;

  int checks = 0;
  int errors = 0;

  control_sequencer dut (
    .clock(clock), .clear_n(clear_n), .run(run), .ir_opcode(ir_opcode),
    .mem_done(mem_done), .pc_out(pc_out), .zlow_out(zlow_out), .mdr_out(mdr_out),
    .r_out(r_out), .ba_out(ba_out), .c_out(c_out), .gra(gra), .grb(grb), .grc(grc),
    .pc_in(pc_in), .mar_in(mar_in), .mdr_in(mdr_in), .ir_in(ir_in), .y_in(y_in),
    .z_in(z_in), .r_in(r_in), .inc_pc(inc_pc), .read(read), .write(write),
    .alu_op(alu_op), .halted(halted), .illegal_op(illegal_op)
  );

  always #5 clock = ~clock;

  // Observed control word, one bit per named output plus alu_op in [3:0].
  logic [24:0] obs;
  assign obs = {pc_out, zlow_out, mdr_out, r_out, ba_out, c_out, gra, grb, grc,
                pc_in, mar_in, mdr_in, ir_in, y_in, z_in, r_in, inc_pc, read, write,
                halted, illegal_op, alu_op};

  localparam logic [24:0] PC_OUT = 25'd1 << 24, ZLOW_OUT = 25'd1 << 23;
  localparam logic [24:0] MDR_OUT = 25'd1 << 22, R_OUT = 25'd1 << 21;
  localparam logic [24:0] BA_OUT = 25'd1 << 20, C_OUT = 25'd1 << 19;
  localparam logic [24:0] GRA = 25'd1 << 18, GRB = 25'd1 << 17, GRC = 25'd1 << 16;
  localparam logic [24:0] PC_IN = 25'd1 << 15, MAR_IN = 25'd1 << 14;
  localparam logic [24:0] MDR_IN = 25'd1 << 13, IR_IN = 25'd1 << 12;
  localparam logic [24:0] Y_IN = 25'd1 << 11, Z_IN = 25'd1 << 10, R_IN = 25'd1 << 9;
  localparam logic [24:0] INC_PC = 25'd1 << 8, READ = 25'd1 << 7, WRITE = 25'd1 << 6;
  localparam logic [24:0] HALTED = 25'd1 << 5, ILLEGAL = 25'd1 << 4;

  localparam logic [4:0] LD = 5'b00000, ST = 5'b00001, ADD = 5'b00011, SUB = 5'b00100;
  localparam logic [4:0] AND_ = 5'b00101, OR_ = 5'b00110, SHR = 5'b00111, SHL = 5'b01000;
  localparam logic [4:0] ADDI = 5'b01100, ANDI = 5'b01101, ORI = 5'b01110;
  localparam logic [4:0] NOP = 5'b11010, HALT = 5'b11011;

  // wait_sel: 0 = no wait, 1 = fetch memory wait, 2 = execute memory wait
  typedef struct {
    logic [24:0] v;
    int          wait_sel;
  } step_t;

  step_t exp_q[$];

  function automatic logic [24:0] ref_alu(input logic [4:0] op);
    case (op)
      SUB:        return 25'd1;
      AND_, ANDI: return 25'd2;
      OR_, ORI:   return 25'd3;
      SHR:        return 25'd4;
      SHL:        return 25'd5;
      default:    return 25'd0;
    endcase
  endfunction

  function automatic void push(input logic [24:0] v, input int w);
    step_t s;
    s.v = v;
    s.wait_sel = w;
    exp_q.push_back(s);
  endfunction

  // Expected control words, one entry per micro-step of the instruction.
  function automatic void build_steps(input logic [4:0] op);
    bit rt, im, ld, st;
    rt = op inside {ADD, SUB, AND_, OR_, SHR, SHL};
    im = op inside {ADDI, ANDI, ORI};
    ld = (op == LD);
    st = (op == ST);
    exp_q.delete();
    push(PC_OUT | MAR_IN | INC_PC | Z_IN, 0);
    push(ZLOW_OUT | PC_IN | READ | MDR_IN, 1);
    push(MDR_OUT | IR_IN, 0);
    if (op == NOP || op == HALT) return;
    if (!(rt || im || ld || st)) begin
      push(ILLEGAL, 0);
      return;
    end
    if (rt || im) push(GRB | R_OUT | Y_IN, 0);
    else          push(GRB | BA_OUT | Y_IN, 0);
    if (rt) push(GRC | R_OUT | Z_IN | ref_alu(op), 0);
    else    push(C_OUT | Z_IN | ref_alu(op), 0);
    if (rt || im) begin
      push(ZLOW_OUT | GRA | R_IN, 0);
      return;
    end
    push(ZLOW_OUT | MAR_IN, 0);
    if (ld) begin
      push(READ | MDR_IN, 2);
      push(MDR_OUT | GRA | R_IN, 0);
    end else begin
      push(GRA | R_OUT | MDR_IN, 0);
      push(WRITE, 2);
    end
  endfunction

  // Steps one instruction from T0, checking the control word every cycle.
  task automatic run_instr(input logic [4:0] op, input int d1, input int d2,
                           output int cyc);
    build_steps(op);
    ir_opcode = op;
    cyc = 0;
    foreach (exp_q[i]) begin
      int w;
      w = (exp_q[i].wait_sel == 1) ? d1 : ((exp_q[i].wait_sel == 2) ? d2 : 0);
      for (int k = 0; k <= w; k++) begin
        checks++;
        if (obs !== exp_q[i].v) begin
          errors++;
          $display("FAIL step op=%b step=%0d hold=%0d got=%h exp=%h", op, i, k, obs, exp_q[i].v);
        end
        if (exp_q[i].wait_sel != 0) mem_done = (k == w);
        else                        mem_done = 1'($urandom_range(0, 1));
        @(negedge clock);
        cyc++;
      end
    end
  endtask

  // Bus sources must be one-hot or zero on every cycle.
  always @(negedge clock) begin
    checks++;
    if ($countones({pc_out, zlow_out, mdr_out, r_out, ba_out, c_out}) > 1) begin
      errors++;
      $display("FAIL bus_onehot got=%b exp=at most one",
               {pc_out, zlow_out, mdr_out, r_out, ba_out, c_out});
    end
  end

  task automatic test_reset();
    int cyc;
    clear_n = 1'b0; run = 1'b0; mem_done = 1'b0; ir_opcode = 5'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (obs !== 25'd0) begin errors++; $display("FAIL reset_state got=%h exp=0", obs); end
    clear_n = 1'b1;
    repeat (2) begin
      @(negedge clock);
      checks++;
      if (obs !== 25'd0) begin errors++; $display("FAIL idle_hold got=%h exp=0", obs); end
    end
    // Run an ADD into T4 and reset it mid-cycle.
    run = 1'b1; ir_opcode = ADD; mem_done = 1'b1;
    repeat (5) @(negedge clock);
    checks++;
    if (obs !== (GRC | R_OUT | Z_IN)) begin
      errors++; $display("FAIL reset_pre_t4 got=%h exp=%h", obs, GRC | R_OUT | Z_IN);
    end
    #2 clear_n = 1'b0;
    #1;
    checks++;
    if (obs !== 25'd0) begin errors++; $display("FAIL reset_async got=%h exp=0", obs); end
    @(negedge clock);
    clear_n = 1'b1;
    @(negedge clock);
    // run still high: back in T0 after one edge; finish that instruction.
    run_instr(ADD, 0, 0, cyc);
  endtask

  task automatic test_add();
    int cyc;
    run_instr(ADD, 0, 0, cyc);
    checks++;
    if (cyc !== 6) begin errors++; $display("FAIL add_cycles got=%0d exp=6", cyc); end
  endtask

  task automatic test_ld_delay();
    int cyc;
    run_instr(LD, 3, 3, cyc);
    checks++;
    if (cyc !== 14) begin errors++; $display("FAIL ld_cycles got=%0d exp=14", cyc); end
  endtask

  task automatic test_st();
    int cyc;
    run_instr(ST, 0, 2, cyc);
    checks++;
    if (cyc !== 10) begin errors++; $display("FAIL st_cycles got=%0d exp=10", cyc); end
    checks++;
    if (obs !== (PC_OUT | MAR_IN | INC_PC | Z_IN)) begin
      errors++; $display("FAIL st_return_t0 got=%h exp=%h", obs, PC_OUT | MAR_IN | INC_PC | Z_IN);
    end
  endtask

  task automatic test_illegal();
    int cyc;
    run_instr(5'b11111, 1, 0, cyc);
    checks++;
    if (cyc !== 5) begin errors++; $display("FAIL illegal_cycles got=%0d exp=5", cyc); end
    checks++;
    if (illegal_op !== 1'b0 || pc_out !== 1'b1) begin
      errors++; $display("FAIL illegal_pulse got=%b/%b exp=0/1", illegal_op, pc_out);
    end
  endtask

  task automatic test_random();
    logic [4:0] pool [15];
    int cyc;
    pool = '{LD, ST, ADD, SUB, AND_, OR_, SHR, SHL, ADDI, ANDI, ORI, NOP,
             5'b00010, 5'b10101, 5'b11111};
    for (int n = 0; n < 60; n++) begin
      run_instr(pool[$urandom_range(0, 14)], $urandom_range(0, 3), $urandom_range(0, 3), cyc);
    end
  endtask

  task automatic test_halt();
    int cyc;
    run_instr(HALT, 2, 0, cyc);
    for (int n = 0; n < 20; n++) begin
      checks++;
      if (obs !== HALTED) begin errors++; $display("FAIL halt_hold n=%0d got=%h exp=%h", n, obs, HALTED); end
      run = 1'($urandom_range(0, 1));
      mem_done = 1'($urandom_range(0, 1));
      ir_opcode = 5'($urandom);
      @(negedge clock);
    end
    clear_n = 1'b0; run = 1'b0;
    #1;
    checks++;
    if (obs !== 25'd0) begin errors++; $display("FAIL halt_clear got=%h exp=0", obs); end
    @(negedge clock);
    clear_n = 1'b1;
    @(negedge clock);
    checks++;
    if (obs !== 25'd0) begin errors++; $display("FAIL post_halt_idle got=%h exp=0", obs); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ld_delay();
    test_st();
    test_illegal();
    test_random();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
